fetch_queue: RTL and testbench

- Sits directly downstream of the PC-generation stage.
- Takes each fetch address from that stage and issues it to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions, each paired with its PC, in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake.
- On a redirect (taken branch/jump), discards all queued and in-flight fetches.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_queue_sync_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: default datapath widths, the fetch entry
// layout handed to decode, a NOP encoding and a small pointer-width helper.
package cpu_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_INST_W = 32;

    // One fetched instruction paired with the PC it was fetched from.
    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // addi x0, x0, 0 -- kept for a later flush-fill option.
    localparam logic [DEF_INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Pointer width for an n-entry ring; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with a separately tracked occupancy count and a
// synchronous clear. The head entry is read straight from registered storage,
// so it holds steady while no pop happens.
module sync_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Ring advance that also handles non power-of-two depths.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clr;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between PC generation and decode. Issues each PC to
// instruction memory when credit allows, pairs returning data with its PC in
// an instruction FIFO, and on a redirect kills queued entries and marks the
// in-flight responses to be discarded as they come back.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INST_W  = DEF_INST_W,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              id_valid_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o,
    input  logic              id_ready_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int AQ_CNT = $clog2(MAX_OUT) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            wr_entry;
    entry_t            head_entry;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  drop_cnt;
    logic [31:0]       in_flight;
    logic [31:0]       in_use;
    logic              credit_ok;
    logic              grant;
    logic              resp_valid;
    logic              drop_hit;
    logic              enq;
    logic              deq;
    logic [ADDR_W-1:0] resp_pc;
    logic              fifo_full;
    logic              fifo_empty;
    logic              aq_full;
    logic              aq_empty;
    logic [AQ_CNT-1:0] aq_count;
    logic              unused_status;

    // Everything in flight (live or doomed) still owns an address-queue slot
    // and, if live, a future FIFO slot, so both limits count the drops too.
    assign in_flight = 32'(outstanding) + 32'(drop_cnt);
    assign in_use    = 32'(count_o) + in_flight;
    assign credit_ok = (in_use < 32'(DEPTH)) && (in_flight < 32'(MAX_OUT));

    assign imem_req_o  = rst_n_i & pc_valid_i & credit_ok & ~flush_i;
    assign imem_addr_o = pc_i;
    assign grant       = imem_req_o & imem_gnt_i;
    assign pc_ready_o  = grant;

    // A response with nothing in flight is stray and touches no state.
    assign resp_valid = imem_rvalid_i & (in_flight != 32'd0);
    assign drop_hit   = resp_valid & (drop_cnt != '0);
    assign enq        = resp_valid & ~drop_hit & ~flush_i;

    assign id_valid_o = ~fifo_empty;
    assign deq        = id_valid_o & id_ready_i;
    assign id_inst_o  = id_valid_o ? head_entry.inst : '0;
    assign id_pc_o    = id_valid_o ? head_entry.pc : '0;

    assign wr_entry.inst = imem_rdata_i;
    assign wr_entry.pc   = resp_pc;

    assign unused_status = &{1'b0, fifo_full, aq_full, aq_empty, aq_count};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (flush_i),
        .push  (enq),
        .wdata (wr_entry),
        .pop   (deq),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count_o)
    );

    // Address queue is never cleared: dropped responses still pop their PC.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUT)
    ) u_addr_queue (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (1'b0),
        .push  (grant),
        .wdata (pc_i),
        .pop   (resp_valid),
        .rdata (resp_pc),
        .full  (aq_full),
        .empty (aq_empty),
        .count (aq_count)
    );

    // Live/doomed in-flight accounting; a flush converts all live requests
    // into drops, less the response (live or doomed) consumed this cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (flush_i) begin
            drop_cnt    <= drop_cnt + outstanding - OUT_W'(resp_valid);
            outstanding <= '0;
        end else begin
            if (drop_hit) begin
                drop_cnt <= drop_cnt - OUT_W'(1);
            end
            outstanding <= outstanding + OUT_W'(grant) - OUT_W'(resp_valid & ~drop_hit);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a random run,
// all compared every cycle against a queue-based model of the fetch path.
module tb_fetch_queue;

    localparam int ADDR_W  = 16;
    localparam int INST_W  = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic [ADDR_W-1:0] pc_i;
    logic              pc_valid_i;
    logic              pc_ready_o;
    logic              flush_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [INST_W-1:0] imem_rdata_i;
    logic              id_valid_o;
    logic [INST_W-1:0] id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic              id_ready_i;
    logic [CNT_W-1:0]  count_o;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i),
        .count_o       (count_o)
    );

    // Model: every granted request in order, each either still wanted or killed.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        bit                live;
    } req_t;
    typedef struct {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    req_t pend[$];
    ent_t fq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int grants_seen = 0;
    int valid_seen  = 0;
    bit last_grant  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare at negedge+1, advance model.
    task automatic step(input bit pv, input logic [ADDR_W-1:0] pc, input bit gnt,
                        input bit rv, input logic [INST_W-1:0] rd, input bit rdy, input bit fl);
        bit   credit;
        bit   exp_req;
        bit   grant;
        req_t r;
        @(negedge clk);
        pc_valid_i    = pv;
        pc_i          = pc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        id_ready_i    = rdy;
        flush_i       = fl;
        #1;
        credit  = (fq.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUT);
        exp_req = pv && credit && !fl;
        grant   = exp_req && gnt;
        chk("imem_req", imem_req_o, exp_req);
        chk("pc_ready", pc_ready_o, grant);
        chk("imem_addr", imem_addr_o, pc);
        chk("id_valid", id_valid_o, fq.size() > 0);
        chk("count", count_o, fq.size());
        if (fq.size() > 0) begin
            chk("id_inst", id_inst_o, fq[0].inst);
            chk("id_pc", id_pc_o, fq[0].pc);
        end else begin
            chk("id_inst_idle", id_inst_o, 0);
            chk("id_pc_idle", id_pc_o, 0);
        end
        if (pc_ready_o) grants_seen++;
        if (id_valid_o) valid_seen++;
        last_grant = grant;
        // advance the model by one clock edge
        if (rv && pend.size() == 0)
            $display("[TB] note: stray rvalid at cycle %0d ignored", cyc);
        if (fl) begin
            if (rv && pend.size() > 0) void'(pend.pop_front());
            fq.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
        end else begin
            if (fq.size() > 0 && rdy) void'(fq.pop_front());
            if (rv && pend.size() > 0) begin
                r = pend.pop_front();
                if (r.live) begin
                    chk("push_on_full", fq.size() < DEPTH, 1);
                    fq.push_back('{inst: rd, pc: r.addr});
                end
            end
        end
        if (grant) pend.push_back('{addr: pc, live: 1'b1});
        cyc++;
    endtask

    // Response data tied to the head address so PC/data pairing is visible.
    function automatic logic [INST_W-1:0] data_for_head();
        return (pend.size() > 0) ? {16'hC0DE, pend[0].addr} : '0;
    endfunction

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 16'h0, 1'b1, pend.size() > 0, data_for_head(), 1'b1, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("rst_id_valid", id_valid_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_id_inst", id_inst_o, 0);
        chk("rst_id_pc", id_pc_o, 0);
        chk("rst_imem_req", imem_req_o, 0);
        chk("rst_pc_ready", pc_ready_o, 0);
        fq.delete();
        pend.delete();
        pc_valid_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        flush_i       = 1'b0;
        @(negedge clk);
        #2;
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] pcv;
        rst_n_i       = 1'b0;
        pc_i          = 16'h1234;
        pc_valid_i    = 1'b1;
        imem_gnt_i    = 1'b1;
        flush_i       = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        id_ready_i    = 1'b1;
        #3;
        chk("reset_id_valid", id_valid_o, 0);
        chk("reset_count", count_o, 0);
        chk("reset_id_inst", id_inst_o, 0);
        chk("reset_id_pc", id_pc_o, 0);
        chk("reset_imem_req", imem_req_o, 0);
        chk("reset_pc_ready", pc_ready_o, 0);
        pc_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Streaming: one per cycle after a two-cycle fill.
        pcv = 16'h0000;
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, pcv, 1'b1, pend.size() > 0, data_for_head(), 1'b1, 1'b0);
            if (i == 1) chk("stream_fill", id_valid_o, 0);
            if (i == 2) begin
                chk("stream_pc0", id_pc_o, 16'h0000);
                chk("stream_inst0", id_inst_o, 32'hC0DE_0000);
            end
            if (i == 3) chk("stream_pc1", id_pc_o, 16'h0004);
            if (i == 4) chk("stream_pc2", id_pc_o, 16'h0008);
            if (last_grant) pcv = pcv + 16'd4;
        end
        chk("stream_throughput", valid_seen, 10);
        drain(4);

        // Backpressure: fill to DEPTH, then one pop frees exactly one request.
        for (int i = 0; i < 10; i++) begin
            if (i == 6) grants_seen = 0;
            step(1'b1, 16'h0100 + 16'(i * 4), 1'b1, pend.size() > 0, data_for_head(), 1'b0, 1'b0);
        end
        chk("bp_count_full", count_o, 4);
        chk("bp_no_grant", grants_seen, 0);
        grants_seen = 0;
        step(1'b1, 16'h0200, 1'b1, pend.size() > 0, data_for_head(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'h0200, 1'b1, pend.size() > 0, data_for_head(), 1'b0, 1'b0);
        chk("bp_one_grant", grants_seen, 1);
        chk("bp_refull", count_o, 4);
        drain(8);

        // Flush with two requests in flight.
        step(1'b1, 16'h0100, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0104, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0);
        chk("flush_nothing_queued", id_valid_o, 0);
        step(1'b1, 16'h0040, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'h1234_0040, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush_next_pc", id_pc_o, 16'h0040);
        chk("flush_next_inst", id_inst_o, 32'h1234_0040);
        drain(3);

        // Flush in the same cycle as a response.
        step(1'b1, 16'h0200, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0204, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h0300, 1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b1);
        step(1'b1, 16'h0300, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush_rv_one_slot", pc_ready_o, 1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'hABCD_0300, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("flush_rv_next_pc", id_pc_o, 16'h0300);
        drain(3);

        // Memory stall: no grant, nothing moves.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0500, 1'b0, 1'b0, '0, 1'b1, 1'b0);
            chk("stall_pc_ready", pc_ready_o, 0);
            chk("stall_addr", imem_addr_o, 16'h0500);
            chk("stall_count", count_o, 0);
        end

        // Async reset with three queued and one in flight, then a late response.
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'h0600 + 16'(i * 4), 1'b1, pend.size() > 0, data_for_head(), 1'b0, 1'b0);
        chk("pre_reset_count", count_o, 2);
        async_reset();
        step(1'b0, 16'h0000, 1'b1, 1'b1, 32'h0000_0BAD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("late_rv_ignored", id_valid_o, 0);
        chk("late_rv_count", count_o, 0);

        // Random traffic including back-to-back flushes.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 16'($urandom) & 16'hFFFC, ($urandom % 4) != 0,
                 (pend.size() > 0) && (($urandom % 3) != 0), $urandom,
                 ($urandom % 3) != 0, ($urandom % 20) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
